// File: rtl/stream_merge_pkg.sv
// rtl/stream_merge_pkg.sv - shared state encoding and width helpers for stream_merge_rr
`timescale 1ns/1ps
package stream_merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A single channel still needs a 1-bit index/tag.
  function automatic int tag_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int DEFAULT_CHANNELS = 4;
  localparam int TAG_W = tag_width(DEFAULT_CHANNELS);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
`timescale 1ns/1ps
module rr_arbiter
  import stream_merge_pkg::*;
#(
  parameter int N     = DEFAULT_CHANNELS,
  parameter int IDX_W = TAG_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int i = N; i >= 1; i--) begin
      sum  = {1'b0, last_grant} + (IDX_W + 1)'(i);
      cand = (sum >= N_W) ? (sum[IDX_W-1:0] - N_W[IDX_W-1:0]) : sum[IDX_W-1:0];
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_merge_rr.sv
// rtl/stream_merge_rr.sv - round-robin N-to-1 stb/ack word merge with sticky exception record
// Optional STREAM_MERGE_RR_TAG_EN adds output_tag carrying the source channel of output_out.
`timescale 1ns/1ps
module stream_merge_rr
  import stream_merge_pkg::*;
#(
  parameter int                      NUM_CHANNELS = 4,
  parameter int                      WIDTH        = 32,
  parameter logic [NUM_CHANNELS-1:0] EXC_MASK     = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANNELS*WIDTH-1:0] input_in,
  input  logic [NUM_CHANNELS-1:0]       input_in_stb,
  output logic [NUM_CHANNELS-1:0]       input_in_ack,
  output logic [WIDTH-1:0]              output_out,
  output logic                          output_out_stb,
  input  logic                          output_out_ack,
  input  logic [NUM_CHANNELS-1:0]       exception_in,
  output logic                          exception,
  output logic [NUM_CHANNELS-1:0]       exception_src
`ifdef STREAM_MERGE_RR_TAG_EN
  ,
  output logic [tag_width(NUM_CHANNELS)-1:0] output_tag
`endif
);

  localparam int IDX_W = tag_width(NUM_CHANNELS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_CHANNELS-1:0] ack_d;
  logic [WIDTH-1:0]        out_d;
  logic                    out_stb_d;
  logic [NUM_CHANNELS-1:0] exc_src_d;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic [WIDTH-1:0]        words [NUM_CHANNELS];

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_words
    assign words[k] = input_in[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N     (NUM_CHANNELS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (input_in_stb),
    .last_grant  (last_grant_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    out_d        = output_out;
    out_stb_d    = output_out_stb;
    exc_src_d    = exception_src | (exception_in & EXC_MASK);
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d        = arb_idx;
          ack_d[arb_idx] = 1'b1;
          state_d        = ACCEPT;
        end
      end
      ACCEPT: begin
        out_d     = words[grant_q];
        out_stb_d = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (output_out_ack) begin
          out_stb_d    = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top channel so channel 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_CHANNELS - 1);
      input_in_ack   <= '0;
      output_out     <= '0;
      output_out_stb <= 1'b0;
      exception_src  <= '0;
      exception      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      input_in_ack   <= ack_d;
      output_out     <= out_d;
      output_out_stb <= out_stb_d;
      exception_src  <= exc_src_d;
      exception      <= |exc_src_d;
    end
  end

`ifdef STREAM_MERGE_RR_TAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      output_tag <= '0;
    end else if (state_q == ACCEPT) begin
      output_tag <= grant_q;
    end
  end
`endif

endmodule

// File: doc/stream_merge_rr.md
Name: stream_merge_rr

Overview:
- Parametrised N-to-1 merge for Chips-style stb/ack word streams.
- Lets several generated processes share one physical output, e.g. rs232_tx or eth_tx.
- Arbitrates among channels round-robin and moves one word at a time.
- Aggregates per-channel exception lines into a sticky summary and a per-source record, so the top level no longer builds a wide OR.

Parameters:
- NUM_CHANNELS, 4, number of input streams (2..16).
- WIDTH, 32, data width of each stream word.
- EXC_MASK, all ones (NUM_CHANNELS bits), per-channel enable for exception aggregation.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- input_in  in  NUM_CHANNELS*WIDTH  flattened input words; channel k occupies bits [k*WIDTH +: WIDTH].
- input_in_stb  in  NUM_CHANNELS  per-channel word-valid; the producer holds it until acked.
- input_in_ack  out  NUM_CHANNELS  per-channel one-cycle accept pulse.
- output_out  out  WIDTH  merged output word.
- output_out_stb  out  1  output word valid.
- output_out_ack  in  1  consumer accept.
- exception_in  in  NUM_CHANNELS  per-channel exception from the processes.
- exception  out  1  sticky OR of the masked exception_src bits.
- exception_src  out  NUM_CHANNELS  sticky per-channel exception record.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Transfer rule: a transfer occurs on a port in any clk edge where its stb and ack are both 1.
- Reset values:
  - input_in_ack = 0, output_out_stb = 0, output_out = 0.
  - exception = 0, exception_src = 0.
  - state = IDLE.
  - last_grant = NUM_CHANNELS-1, so channel 0 has top priority after reset.
- State machine:
  - IDLE: if any input_in_stb bit is 1, set grant = first requesting channel scanning from last_grant+1 upward (mod NUM_CHANNELS), then go to ACCEPT. If none is requesting, stay in IDLE.
  - ACCEPT: input_in_ack[grant] = 1 for exactly one cycle. Capture input_in channel grant into the output register. Set output_out_stb = 1 from the next cycle. Go to SEND.
  - SEND: hold output_out and output_out_stb stable until output_out_ack = 1. On that edge: drop stb, set last_grant = grant, return to IDLE.
- Latency and throughput:
  - Minimum latency from input stb to output stb is 2 cycles.
  - Peak throughput is one word per 3 cycles when output_out_ack is tied high.
- Input ack discipline:
  - At most one input_in_ack bit is high at any time.
  - Ack is never asserted for a channel whose stb is 0 in that cycle.
  - Grant is latched in IDLE and does not change in ACCEPT or SEND, even if other channels raise stb.
- Fairness: every continuously requesting channel is served within NUM_CHANNELS words.
- Simultaneous requests: resolved purely by round-robin order. Example with N=4, last_grant=1 and channels 0 and 3 both requesting: channel 3 wins.
- Exceptions:
  - exception_src[k] is set on any cycle where exception_in[k] & EXC_MASK[k] is 1, and is cleared only by rst.
  - exception = |exception_src, registered, with the same cycle alignment as exception_src.
  - Exception tracking is independent of the stream state.
- Reset mid-operation:
  - A word already acked but not yet sent is dropped.
  - Producers still holding stb are re-arbitrated from channel 0.
  - An output_out_ack arriving in the reset cycle is ignored.
- Output side: the block tolerates output_out_ack being held permanently high. output_out_ack while output_out_stb = 0 has no effect.

Optional Feature:
- Macro: STREAM_MERGE_RR_TAG_EN.
- When defined:
  - Adds output port output_tag (out, max(1, clog2(NUM_CHANNELS)) bits) carrying the source channel index of the current output word.
  - output_tag is registered with output_out, reset value 0, and held stable during SEND.
- When undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package stream_merge_pkg holds:
  - the state encoding (IDLE=0, ACCEPT=1, SEND=2, 2-bit);
  - a clog2 constant function;
  - a localparam for the tag width.
- One natural sub-module: rr_arbiter. It is purely combinational, takes (req[N-1:0], last_grant) and returns (grant_idx, grant_valid), and is instantiated once.

Test Plan:
- Single word: rst, then channel 2 stb=1 with data 0x0000_0041, output_out_ack=1 → input_in_ack[2] pulses for one cycle, 1 cycle after stb. output_out=0x41 with stb the following cycle. With TAG_EN, output_tag=2.
- Round-robin: N=4, channels 0, 1 and 3 all hold stb with data 0xA0, 0xA1 and 0xA3, ack tied high → output order 0xA0, 0xA1, 0xA3, 0xA0. Exactly 3 cycles between output stbs.
- Backpressure: output_out_ack=0 for 10 cycles while channel 1 sends 0xDEADBEEF → output_out_stb and output_out stay stable for all 10 cycles. No further input_in_ack occurs. Completes on the first ack=1.
- Exceptions: EXC_MASK=4'b1011, pulse exception_in=4'b0100, then 4'b1000 → exception_src=4'b1000 and exception=1 one cycle after the second pulse. Both stay high until rst.
- Reset mid-SEND: channel 0 word acked and output_out_stb=1, then assert rst for one cycle → next cycle output_out_stb=0 and exception_src=0. A held channel 3 request is next accepted before channel 0 only if channel 0 is not requesting.
- Width and channel sweep: N=2/WIDTH=8 and N=16/WIDTH=32 with random stb/ack, checked against a scoreboard → no loss, no duplication, per-channel order preserved, at most one input_in_ack bit set in any cycle.
